// File: rtl/misr_session_ctrl.sv
// Sequences one MISR signature-test session: seed, capture window with an optional
// single bit-flip injection, drain, then compare both signatures against golden values.
module misr_session_ctrl #(
    parameter int         MISR_W   = 3,
    parameter int         CYC_W    = 8,
    parameter int         LAT      = 1,
    parameter logic [3:0] NONE_SEL = 4'h8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CYC_W-1:0]  run_len,
    input  logic              inj_en,
    input  logic [2:0]        inj_slot,
    input  logic [CYC_W-1:0]  inj_cyc,
    input  logic [MISR_W-1:0] golden_a,
    input  logic [MISR_W-1:0] golden_b,
    input  logic [MISR_W-1:0] sig_a,
    input  logic [MISR_W-1:0] sig_b,
    output logic              m_rst,
    output logic              cap_en,
    output logic [3:0]        binary_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_mask,
    output logic              inj_fired,
    output logic [CYC_W-1:0]  cycle_cnt
);
    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_RUN, S_DRAIN, S_CHECK, S_DONE
    } state_t;

    localparam logic [3:0] DRAIN_LAST = (LAT > 0) ? 4'(LAT - 1) : 4'd0;
    localparam state_t     AFTER_RUN  = (LAT == 0) ? S_CHECK : S_DRAIN;

    state_t            state_q, state_d;
    logic [CYC_W-1:0]  cycle_cnt_q, cnt_d;
    logic [3:0]        drain_q;
    logic [CYC_W-1:0]  run_len_q, inj_cyc_q;
    logic              inj_en_q;
    logic [2:0]        inj_slot_q;
    logic [MISR_W-1:0] gold_q [2];
    logic [MISR_W-1:0] sig_arr [2];
    logic [1:0]        mismatch;
    logic              abort_hit, inj_hit;
    logic [CYC_W-1:0]  run_last;

    logic              m_rst_q, cap_en_q, busy_q, done_q, pass_q, inj_fired_q;
    logic [3:0]        binary_in_q;
    logic [1:0]        fail_mask_q;

    assign sig_arr[0] = sig_a;
    assign sig_arr[1] = sig_b;

    // Bit gi of the mask flags MISR gi+1 disagreeing with its latched golden value.
    for (genvar gi = 0; gi < 2; gi++) begin : g_cmp
        assign mismatch[gi] = (sig_arr[gi] != gold_q[gi]);
    end

    assign run_last = run_len_q - CYC_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cycle_cnt_q;
        abort_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SEED;
                    cnt_d   = '0;
                end
            end
            S_SEED:  state_d = (run_len_q == '0) ? AFTER_RUN : S_RUN;
            S_RUN: begin
                if (cycle_cnt_q == run_last) begin
                    state_d = AFTER_RUN;
                end else begin
                    cnt_d = cycle_cnt_q + CYC_W'(1);
                end
            end
            S_DRAIN: if (drain_q == DRAIN_LAST) state_d = S_CHECK;
            S_CHECK: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE && state_q != S_DONE) begin
            abort_hit = 1'b1;
            state_d   = S_DONE;
            cnt_d     = cycle_cnt_q;
        end
        // Decided on the next-state values so the select lines up with its RUN cycle.
        inj_hit = inj_en_q && (state_d == S_RUN) && (cnt_d == inj_cyc_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cycle_cnt_q <= '0;
            drain_q     <= '0;
            run_len_q   <= '0;
            inj_cyc_q   <= '0;
            inj_en_q    <= 1'b0;
            inj_slot_q  <= '0;
            gold_q[0]   <= '0;
            gold_q[1]   <= '0;
            m_rst_q     <= 1'b1;
            cap_en_q    <= 1'b0;
            binary_in_q <= NONE_SEL;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= 2'b00;
            inj_fired_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cnt_d;
            drain_q     <= (state_q == S_DRAIN) ? drain_q + 4'd1 : 4'd0;
            m_rst_q     <= (state_d == S_IDLE) || (state_d == S_SEED);
            cap_en_q    <= (state_d == S_RUN);
            busy_q      <= state_d inside {S_SEED, S_RUN, S_DRAIN, S_CHECK};
            done_q      <= (state_d == S_DONE);
            binary_in_q <= inj_hit ? {1'b0, inj_slot_q} : NONE_SEL;
            if (inj_hit) begin
                inj_fired_q <= 1'b1;
            end
            if (state_q == S_IDLE && start) begin
                run_len_q   <= run_len;
                inj_en_q    <= inj_en;
                inj_slot_q  <= inj_slot;
                inj_cyc_q   <= inj_cyc;
                gold_q[0]   <= golden_a;
                gold_q[1]   <= golden_b;
                pass_q      <= 1'b0;
                fail_mask_q <= 2'b00;
                inj_fired_q <= 1'b0;
            end
            if (state_d == S_DONE) begin
                fail_mask_q <= abort_hit ? 2'b11 : mismatch;
                pass_q      <= !abort_hit && (mismatch == 2'b00);
            end
        end
    end

    assign m_rst     = m_rst_q;
    assign cap_en    = cap_en_q;
    assign binary_in = binary_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_mask = fail_mask_q;
    assign inj_fired = inj_fired_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_misr_session_ctrl.sv
// Bench for misr_session_ctrl: a session-timeline model checked every cycle,
// directed sessions with literal expectations, then randomized traffic.
module tb_misr_session_ctrl;
    localparam int         MISR_W = 3;
    localparam int         CYC_W  = 8;
    localparam int         LAT    = 1;
    localparam logic [3:0] NONE   = 4'h8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, start, abort, inj_en;
    logic [CYC_W-1:0]  run_len, inj_cyc;
    logic [2:0]        inj_slot;
    logic [MISR_W-1:0] golden_a, golden_b, sig_a, sig_b;
    logic              m_rst, cap_en, busy, done, pass, inj_fired;
    logic [3:0]        binary_in;
    logic [1:0]        fail_mask;
    logic [CYC_W-1:0]  cycle_cnt;

    misr_session_ctrl #(.MISR_W(MISR_W), .CYC_W(CYC_W), .LAT(LAT), .NONE_SEL(NONE)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .run_len(run_len),
        .inj_en(inj_en), .inj_slot(inj_slot), .inj_cyc(inj_cyc),
        .golden_a(golden_a), .golden_b(golden_b), .sig_a(sig_a), .sig_b(sig_b),
        .m_rst(m_rst), .cap_en(cap_en), .binary_in(binary_in), .busy(busy),
        .done(done), .pass(pass), .fail_mask(fail_mask), .inj_fired(inj_fired),
        .cycle_cnt(cycle_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Model: k counts cycles since the accepting edge; session ends in cycle done_k.
    bit                sess = 0;
    bit                m_en, m_abort;
    int                k, done_k, m_len, m_cyc;
    logic [2:0]        m_slot;
    logic [MISR_W-1:0] m_ga, m_gb;
    logic              e_m_rst, e_cap, e_busy, e_done, e_pass, e_fired;
    logic [3:0]        e_bin;
    logic [1:0]        e_mask;
    logic [CYC_W-1:0]  e_cnt;

    initial forever begin
        @(posedge clk);
        if (!rst) begin
            sess = 0;
            e_m_rst = 1; e_cap = 0; e_bin = NONE; e_busy = 0; e_done = 0;
            e_pass = 0; e_mask = 0; e_fired = 0; e_cnt = 0;
        end else if (!sess) begin
            e_done = 0; e_m_rst = 1; e_cap = 0; e_bin = NONE; e_busy = 0;
            if (start) begin
                sess = 1; k = 0; m_abort = 0;
                m_len = int'(run_len); m_en = inj_en; m_slot = inj_slot; m_cyc = int'(inj_cyc);
                m_ga = golden_a; m_gb = golden_b;
                done_k = m_len + LAT + 2;
                e_pass = 0; e_mask = 0; e_fired = 0; e_cnt = 0; e_busy = 1;
            end
        end else begin
            if (abort && k < done_k) begin
                m_abort = 1;
                done_k  = k + 1;
            end else if (k == done_k) begin
                sess = 0;
            end
            k++;
            if (!sess) begin
                e_done = 0; e_m_rst = 1; e_busy = 0; e_cap = 0; e_bin = NONE;
            end else if (k == done_k) begin
                e_done = 1; e_busy = 0; e_m_rst = 0; e_cap = 0; e_bin = NONE;
                e_mask = m_abort ? 2'b11 : {sig_b != m_gb, sig_a != m_ga};
                e_pass = (e_mask == 2'b00);
            end else if (k <= m_len) begin
                e_m_rst = 0; e_cap = 1; e_busy = 1;
                e_cnt = CYC_W'(k - 1);
                e_bin = (m_en && (k - 1) == m_cyc) ? {1'b0, m_slot} : NONE;
                if (e_bin != NONE) e_fired = 1;
            end else begin
                e_m_rst = 0; e_cap = 0; e_busy = 1; e_bin = NONE;
            end
        end
    end

    bit         chk_en = 0;
    int         cap_seen = 0, inj_seen = 0, done_seen = 0;
    logic [7:0] inj_at_cnt = '0;

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            cmp("m_rst",     32'(m_rst),     32'(e_m_rst));
            cmp("cap_en",    32'(cap_en),    32'(e_cap));
            cmp("binary_in", 32'(binary_in), 32'(e_bin));
            cmp("busy",      32'(busy),      32'(e_busy));
            cmp("done",      32'(done),      32'(e_done));
            cmp("pass",      32'(pass),      32'(e_pass));
            cmp("fail_mask", 32'(fail_mask), 32'(e_mask));
            cmp("inj_fired", 32'(inj_fired), 32'(e_fired));
            cmp("cycle_cnt", 32'(cycle_cnt), 32'(e_cnt));
            if (cap_en === 1'b1) cap_seen++;
            if (binary_in !== NONE) begin
                inj_seen++;
                inj_at_cnt = cycle_cnt;
            end
            if (done === 1'b1) done_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one session; off is the cycle offset of done after the accepting edge, -1 on timeout.
    task automatic session(input int len, input int en, input int slot, input int cyc,
                           input int ga, input int gb, input int sa, input int sb,
                           input int abort_at, input int restart_at, output int off);
        int n;
        run_len = CYC_W'(len); inj_en = 1'(en); inj_slot = 3'(slot); inj_cyc = CYC_W'(cyc);
        golden_a = MISR_W'(ga); golden_b = MISR_W'(gb); sig_a = MISR_W'(sa); sig_b = MISR_W'(sb);
        start = 1;
        tick();
        start = 0;
        run_len = CYC_W'($urandom); inj_en = 1'($urandom); inj_slot = 3'($urandom);
        inj_cyc = CYC_W'($urandom); golden_a = MISR_W'($urandom); golden_b = MISR_W'($urandom);
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            abort = (n == abort_at);
            start = (n == restart_at);
            tick();
            n++;
        end
        abort = 0;
        start = 0;
        off = (done === 1'b1) ? n : -1;
    endtask

    initial begin
        int off, c0, i0, d0;
        rst = 0; start = 0; abort = 0; inj_en = 0; run_len = '0; inj_cyc = '0; inj_slot = '0;
        golden_a = '0; golden_b = '0; sig_a = '0; sig_b = '0;
        tick();
        chk_en = 1;
        tick();
        cmp("reset_m_rst", 32'(m_rst), 32'd1);
        cmp("reset_binary_in", 32'(binary_in), 32'h8);
        cmp("reset_busy", 32'(busy), 32'd0);
        rst = 1;
        tick();

        // Clean run
        c0 = cap_seen; i0 = inj_seen;
        session(4, 0, 0, 0, 1, 4, 1, 4, -1, -1, off);
        cmp("clean_done_offset", 32'(off), 32'd7);
        cmp("clean_pass", 32'(pass), 32'd1);
        cmp("clean_mask", 32'(fail_mask), 32'd0);
        cmp("clean_cap_cycles", 32'(cap_seen - c0), 32'd4);
        cmp("clean_inj_cycles", 32'(inj_seen - i0), 32'd0);
        tick(); tick();

        // Injection at RUN cycle 1 corrupting MISR 1
        i0 = inj_seen;
        session(4, 1, 5, 1, 1, 4, 6, 4, -1, -1, off);
        cmp("inj_done_offset", 32'(off), 32'd7);
        cmp("inj_cycles", 32'(inj_seen - i0), 32'd1);
        cmp("inj_at_cnt", 32'(inj_at_cnt), 32'd1);
        cmp("inj_fired", 32'(inj_fired), 32'd1);
        cmp("inj_pass", 32'(pass), 32'd0);
        cmp("inj_mask", 32'(fail_mask), 32'd1);
        tick(); tick();

        // Injection cycle beyond run length
        i0 = inj_seen;
        session(4, 1, 3, 6, 1, 4, 1, 4, -1, -1, off);
        cmp("oor_inj_cycles", 32'(inj_seen - i0), 32'd0);
        cmp("oor_inj_fired", 32'(inj_fired), 32'd0);
        cmp("oor_pass", 32'(pass), 32'd1);
        tick(); tick();

        // Zero length with a second start while busy
        c0 = cap_seen; d0 = done_seen;
        session(0, 0, 0, 0, 2, 2, 2, 2, -1, 1, off);
        cmp("zero_done_offset", 32'(off), 32'd3);
        cmp("zero_cap_cycles", 32'(cap_seen - c0), 32'd0);
        repeat (8) tick();
        cmp("zero_done_pulses", 32'(done_seen - d0), 32'd1);
        cmp("zero_idle_busy", 32'(busy), 32'd0);

        // Abort in RUN cycle 1 with injection pending at cycle 2
        i0 = inj_seen;
        session(6, 1, 2, 2, 1, 4, 1, 4, 2, -1, off);
        cmp("abort_done_offset", 32'(off), 32'd3);
        cmp("abort_pass", 32'(pass), 32'd0);
        cmp("abort_mask", 32'(fail_mask), 32'd3);
        cmp("abort_inj_cycles", 32'(inj_seen - i0), 32'd0);
        tick(); tick();

        // Reset during RUN cycle 2
        run_len = 8'd6; inj_en = 0; start = 1;
        tick();
        start = 0;
        repeat (3) tick();
        cmp("mid_run_cnt", 32'(cycle_cnt), 32'd2);
        rst = 0;
        tick();
        rst = 1;
        d0 = done_seen;
        cmp("rst_m_rst", 32'(m_rst), 32'd1);
        cmp("rst_binary_in", 32'(binary_in), 32'h8);
        cmp("rst_busy", 32'(busy), 32'd0);
        cmp("rst_done", 32'(done), 32'd0);
        repeat (12) tick();
        cmp("rst_no_done", 32'(done_seen - d0), 32'd0);

        // Randomized traffic against the model
        d0 = done_seen;
        for (int c = 0; c < 3000; c++) begin
            if (c % 40 == 0) begin
                sig_a = MISR_W'($urandom);
                sig_b = MISR_W'($urandom);
            end
            start    = ($urandom_range(5) == 0);
            abort    = ($urandom_range(30) == 0);
            rst      = ($urandom_range(400) != 0);
            run_len  = CYC_W'($urandom_range(12));
            inj_en   = 1'($urandom);
            inj_slot = 3'($urandom);
            inj_cyc  = CYC_W'($urandom_range(14));
            golden_a = ($urandom_range(3) != 0) ? sig_a : MISR_W'($urandom);
            golden_b = ($urandom_range(3) != 0) ? sig_b : MISR_W'($urandom);
            tick();
        end
        start = 0; abort = 0; rst = 1;
        repeat (40) tick();
        if (done_seen - d0 < 20) begin
            checks++;
            errors++;
            $display("FAIL random_sessions actual=%0d required>=20", done_seen - d0);
        end else begin
            checks++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
